// File: rtl/dcache_direct_mapped_pkg.sv
// Shared types for the direct-mapped data cache: CPU access sizes, miss FSM states,
// address-split width helpers and the byte-enable mapping used for write merges.
package cache_interface_types;
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } cache_access_size_t;
endpackage

package dcache_types;
    import cache_interface_types::*;

    typedef enum logic [1:0] {
        READY     = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } dcache_state_t;

    localparam int MAX_WORD_BYTES = 8;

    function automatic int offset_width(input int line_size);
        return $clog2(line_size / 8);
    endfunction

    function automatic int index_width(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_width(input int addr_size, input int line_size, input int num_lines);
        return addr_size - offset_width(line_size) - index_width(num_lines);
    endfunction

    // Byte lanes touched by an access of the given size, positioned within its word.
    function automatic logic [MAX_WORD_BYTES-1:0] byte_enable(input cache_access_size_t size,
                                                              input int unsigned offset,
                                                              input int unsigned word_bytes);
        logic [MAX_WORD_BYTES-1:0] base;
        case (size)
            BYTE:    base = MAX_WORD_BYTES'(1);
            HALF:    base = MAX_WORD_BYTES'(3);
            default: base = {MAX_WORD_BYTES{1'b1}} >> (MAX_WORD_BYTES - word_bytes);
        endcase
        return base << (offset % word_bytes);
    endfunction
endpackage

// File: rtl/dcache_direct_mapped_if.sv
// CPU-side cache bus: the pipeline memory stage is the master, the cache is the slave.
interface cache_interface #(
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32
);
    import cache_interface_types::*;

    logic [ADDR_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] rd_data;
    cache_access_size_t   rd_size;
    logic [WORD_SIZE-1:0] wr_data;
    cache_access_size_t   wr_size;
    logic                 write;
    logic                 access;
    logic                 hit;

    modport master (
        output addr, rd_size, wr_data, wr_size, write, access,
        input  rd_data, hit
    );

    modport slave (
        input  addr, rd_size, wr_data, wr_size, write, access,
        output rd_data, hit
    );
endinterface

// File: rtl/dcache_direct_mapped_line_array.sv
// Line storage: combinational read of valid/dirty/tag/data at i_idx, synchronous write
// with per-byte data enables; only valid/dirty are reset.
module dcache_line_array #(
    parameter  int LINE_SIZE  = 128,
    parameter  int NUM_LINES  = 16,
    parameter  int TAG_W      = 24,
    localparam int IDX_W      = $clog2(NUM_LINES),
    localparam int LINE_BYTES = LINE_SIZE / 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [IDX_W-1:0]      i_idx,
    output logic                  o_valid,
    output logic                  o_dirty,
    output logic [TAG_W-1:0]      o_tag,
    output logic [LINE_SIZE-1:0]  o_data,
    input  logic                  i_data_we,
    input  logic [LINE_BYTES-1:0] i_data_be,
    input  logic [LINE_SIZE-1:0]  i_data,
    input  logic                  i_meta_we,
    input  logic                  i_meta_dirty,
    input  logic [TAG_W-1:0]      i_meta_tag
);
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_SIZE-1:0] r_data [NUM_LINES];

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_data  = r_data[i_idx];

    // A metadata write always leaves the line valid; lines only become invalid on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_meta_we) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= i_meta_dirty;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_meta_we) begin
            r_tag[i_idx] <= i_meta_tag;
        end
        if (i_data_we) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (i_data_be[b]) begin
                    r_data[i_idx][8*b +: 8] <= i_data[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back/write-allocate D-cache; hits answer in the same cycle, misses stall
// the bus (hit=0) through WRITEBACK/FILL until mem_ready_i. DCACHE_STATS_EN enables hit/miss counters.
module dcache_direct_mapped
    import cache_interface_types::*;
    import dcache_types::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32,
    parameter int LINE_SIZE = 128,
    parameter int NUM_LINES = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    cache_interface.slave        cache_bus,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [LINE_SIZE-1:0] mem_wr_data_o,
    input  logic [LINE_SIZE-1:0] mem_rd_data_i,
    output logic                 mem_write_o,
    output logic                 mem_valid_o,
    input  logic                 mem_ready_i,
    output logic [31:0]          hit_count_o,
    output logic [31:0]          miss_count_o
);
    localparam int OFF_W      = offset_width(LINE_SIZE);
    localparam int IDX_W      = index_width(NUM_LINES);
    localparam int TAG_W      = tag_width(ADDR_SIZE, LINE_SIZE, NUM_LINES);
    localparam int LINE_BYTES = LINE_SIZE / 8;
    localparam int WORD_BYTES = WORD_SIZE / 8;

    logic [OFF_W-1:0]          w_off;
    logic [IDX_W-1:0]          w_idx;
    logic [TAG_W-1:0]          w_tag;
    logic [IDX_W-1:0]          w_arr_idx;
    logic                      w_arr_valid;
    logic                      w_arr_dirty;
    logic [TAG_W-1:0]          w_arr_tag;
    logic [LINE_SIZE-1:0]      w_arr_data;
    logic                      w_hit;
    logic                      w_miss;
    logic                      w_wr_hit;
    logic                      w_mem_done;
    logic [MAX_WORD_BYTES-1:0] w_be;
    logic [LINE_BYTES-1:0]     w_line_be;
    logic [LINE_SIZE-1:0]      w_wr_line;
    logic [WORD_SIZE-1:0]      w_rd_word;
    logic [WORD_SIZE-1:0]      w_rd_data;
    logic                      w_data_we;
    logic [LINE_BYTES-1:0]     w_data_be;
    logic [LINE_SIZE-1:0]      w_data_line;
    logic                      w_meta_we;
    logic                      w_meta_dirty;
    logic [TAG_W-1:0]          w_meta_tag;

    dcache_state_t        r_state;
    logic [IDX_W-1:0]     r_miss_idx;
    logic [TAG_W-1:0]     r_fill_tag;
    logic [ADDR_SIZE-1:0] r_mem_addr;
    logic [LINE_SIZE-1:0] r_mem_wr_data;
    logic                 r_mem_write;
    logic                 r_mem_valid;

    assign w_off = cache_bus.addr[OFF_W-1:0];
    assign w_idx = cache_bus.addr[OFF_W +: IDX_W];
    assign w_tag = cache_bus.addr[ADDR_SIZE-1 -: TAG_W];

    // Once a miss is in flight the line is addressed by the latched index, so a master
    // that drops or changes the request cannot redirect the writeback/fill.
    assign w_arr_idx = (r_state == READY) ? w_idx : r_miss_idx;

    dcache_line_array #(
        .LINE_SIZE (LINE_SIZE),
        .NUM_LINES (NUM_LINES),
        .TAG_W     (TAG_W)
    ) u_lines (
        .i_clk        (clk_i),
        .i_rst        (reset_i),
        .i_idx        (w_arr_idx),
        .o_valid      (w_arr_valid),
        .o_dirty      (w_arr_dirty),
        .o_tag        (w_arr_tag),
        .o_data       (w_arr_data),
        .i_data_we    (w_data_we),
        .i_data_be    (w_data_be),
        .i_data       (w_data_line),
        .i_meta_we    (w_meta_we),
        .i_meta_dirty (w_meta_dirty),
        .i_meta_tag   (w_meta_tag)
    );

    assign w_hit      = cache_bus.access && (r_state == READY) && w_arr_valid && (w_arr_tag == w_tag);
    assign w_miss     = cache_bus.access && (r_state == READY) && !w_hit;
    assign w_wr_hit   = w_hit && cache_bus.write;
    assign w_mem_done = r_mem_valid && mem_ready_i;

    assign w_rd_word = WORD_SIZE'(w_arr_data >> {w_off, 3'b000});

    always_comb begin
        w_rd_data = '0;
        case (cache_bus.rd_size)
            BYTE:    w_rd_data = WORD_SIZE'(w_rd_word[7:0]);
            HALF:    w_rd_data = WORD_SIZE'(w_rd_word[15:0]);
            default: w_rd_data = w_rd_word;
        endcase
    end

    assign cache_bus.rd_data = w_rd_data;
    assign cache_bus.hit     = w_hit;

    assign w_be      = byte_enable(cache_bus.wr_size, 32'(w_off), 32'(WORD_BYTES));
    assign w_line_be = LINE_BYTES'(w_be) << (w_off & ~OFF_W'(WORD_BYTES - 1));
    assign w_wr_line = LINE_SIZE'(cache_bus.wr_data) << {w_off, 3'b000};

    always_comb begin
        w_data_we    = 1'b0;
        w_data_be    = '0;
        w_data_line  = w_wr_line;
        w_meta_we    = 1'b0;
        w_meta_dirty = 1'b0;
        w_meta_tag   = w_arr_tag;
        case (r_state)
            READY: begin
                if (w_wr_hit) begin
                    w_data_we    = 1'b1;
                    w_data_be    = w_line_be;
                    w_meta_we    = 1'b1;
                    w_meta_dirty = 1'b1;
                end
            end
            WRITEBACK: begin
                w_meta_we = w_mem_done;
            end
            FILL: begin
                w_data_we   = w_mem_done;
                w_data_be   = '1;
                w_data_line = mem_rd_data_i;
                w_meta_we   = w_mem_done;
                w_meta_tag  = r_fill_tag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state       <= READY;
            r_miss_idx    <= '0;
            r_fill_tag    <= '0;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
            r_mem_write   <= 1'b0;
            r_mem_valid   <= 1'b0;
        end else begin
            case (r_state)
                READY: begin
                    if (w_miss) begin
                        r_miss_idx  <= w_idx;
                        r_fill_tag  <= w_tag;
                        r_mem_valid <= 1'b1;
                        if (w_arr_valid && w_arr_dirty) begin
                            r_state       <= WRITEBACK;
                            r_mem_addr    <= {w_arr_tag, w_idx, {OFF_W{1'b0}}};
                            r_mem_wr_data <= w_arr_data;
                            r_mem_write   <= 1'b1;
                        end else begin
                            r_state     <= FILL;
                            r_mem_addr  <= {w_tag, w_idx, {OFF_W{1'b0}}};
                            r_mem_write <= 1'b0;
                        end
                    end
                end
                WRITEBACK: begin
                    if (w_mem_done) begin
                        r_state     <= FILL;
                        r_mem_addr  <= {r_fill_tag, r_miss_idx, {OFF_W{1'b0}}};
                        r_mem_write <= 1'b0;
                    end
                end
                FILL: begin
                    if (w_mem_done) begin
                        r_state     <= READY;
                        r_mem_valid <= 1'b0;
                    end
                end
                default: r_state <= READY;
            endcase
        end
    end

    assign mem_addr_o    = r_mem_addr;
    assign mem_wr_data_o = r_mem_wr_data;
    assign mem_write_o   = r_mem_write;
    assign mem_valid_o   = r_mem_valid;

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit)  r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_count_o  = r_hit_cnt;
    assign miss_count_o = r_miss_cnt;
`else
    assign hit_count_o  = '0;
    assign miss_count_o = '0;
`endif
endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Bench for dcache_direct_mapped: directed scenarios plus random accesses against a
// line-level cache/memory model, with a per-cycle compare of bus and memory-port outputs.
module tb_dcache_direct_mapped;
    import cache_interface_types::*;

`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_i;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wr_data_o;
    logic [127:0] mem_rd_data_i;
    logic         mem_write_o;
    logic         mem_valid_o;
    logic         mem_ready_i;
    logic [31:0]  hit_count_o;
    logic [31:0]  miss_count_o;

    cache_interface #(.ADDR_SIZE(32), .WORD_SIZE(32)) bus ();

    dcache_direct_mapped dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .cache_bus     (bus),
        .mem_addr_o    (mem_addr_o),
        .mem_wr_data_o (mem_wr_data_o),
        .mem_rd_data_i (mem_rd_data_i),
        .mem_write_o   (mem_write_o),
        .mem_valid_o   (mem_valid_o),
        .mem_ready_i   (mem_ready_i),
        .hit_count_o   (hit_count_o),
        .miss_count_o  (miss_count_o)
    );

    always #5 clk = ~clk;

    logic [127:0] main_mem [logic [31:0]];
    bit           m_valid [16];
    bit           m_dirty [16];
    logic [23:0]  m_tag   [16];
    logic [127:0] m_data  [16];

    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned exp_hits = 0;
    int unsigned exp_misses = 0;
    bit          exp_on = 1'b0;
    bit          exp_hit = 1'b0;
    bit          exp_rdchk = 1'b0;
    bit          exp_mv = 1'b0;
    bit          exp_mwr = 1'b0;
    logic [31:0] exp_rd = '0;
    logic [31:0] exp_maddr = '0;
    logic [127:0] exp_mwd = '0;
    logic [127:0] wb_obs = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input cache_access_size_t sz);
        return (sz == BYTE) ? 1 : (sz == HALF) ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_read(input logic [127:0] line, input int off, input cache_access_size_t sz);
        logic [31:0] r = '0;
        for (int b = 0; b < nbytes(sz); b++) r[8*b +: 8] = line[8*(off+b) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] m_write(input logic [127:0] line, input int off,
                                             input cache_access_size_t sz, input logic [31:0] wd);
        logic [127:0] l = line;
        for (int b = 0; b < nbytes(sz); b++) l[8*(off+b) +: 8] = wd[8*b +: 8];
        return l;
    endfunction

    task automatic get_line(input logic [31:0] a, output logic [127:0] line);
        if (!main_mem.exists(a)) main_mem[a] = {$urandom, $urandom, $urandom, $urandom};
        line = main_mem[a];
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    always @(negedge clk) begin
        if (exp_on) begin
            chk("hit", bus.hit, exp_hit);
            if (exp_hit && exp_rdchk) chk("rd_data", bus.rd_data, exp_rd);
            chk("mem_valid", mem_valid_o, exp_mv);
            if (exp_mv) begin
                chk("mem_addr", mem_addr_o, exp_maddr);
                chk("mem_write", mem_write_o, exp_mwr);
                if (exp_mwr) chk("mem_wr_data", mem_wr_data_o, exp_mwd);
            end
            chk("hit_count", hit_count_o, STATS ? exp_hits : 0);
            chk("miss_count", miss_count_o, STATS ? exp_misses : 0);
        end
    end

    // One CPU access from presentation to its hit cycle, with the expected memory traffic.
    task automatic access(input logic [31:0] a, input bit wr, input cache_access_size_t sz,
                          input logic [31:0] wd, input int wb_w, input int fill_w,
                          output logic [31:0] rd_obs);
        int           idx;
        int           off;
        logic [23:0]  tg;
        logic [31:0]  vaddr;
        logic [31:0]  faddr;
        logic [127:0] line;
        idx = int'(a[7:4]);
        off = int'(a[3:0]);
        tg  = a[31:8];
        bus.addr    = a;
        bus.write   = wr;
        bus.rd_size = sz;
        bus.wr_size = sz;
        bus.wr_data = wd;
        bus.access  = 1'b1;
        exp_on = 1'b1;
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            exp_hit = 1'b0;
            exp_mv  = 1'b0;
            mem_ready_i = 1'($urandom_range(0, 1));
            cyc();
            exp_misses++;
            if (m_valid[idx] && m_dirty[idx]) begin
                vaddr = {m_tag[idx], a[7:4], 4'h0};
                exp_mv = 1'b1; exp_mwr = 1'b1; exp_maddr = vaddr; exp_mwd = m_data[idx];
                mem_ready_i = 1'b0;
                repeat (wb_w) cyc();
                mem_ready_i = 1'b1;
                @(negedge clk);
                wb_obs = mem_wr_data_o;
                cyc();
                main_mem[vaddr] = m_data[idx];
                m_dirty[idx] = 1'b0;
            end
            faddr = {tg, a[7:4], 4'h0};
            get_line(faddr, line);
            exp_mv = 1'b1; exp_mwr = 1'b0; exp_maddr = faddr;
            mem_ready_i = 1'b0;
            mem_rd_data_i = {$urandom, $urandom, $urandom, $urandom};
            repeat (fill_w) cyc();
            mem_ready_i = 1'b1;
            mem_rd_data_i = line;
            cyc();
            m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0; m_tag[idx] = tg; m_data[idx] = line;
        end
        exp_hit = 1'b1; exp_mv = 1'b0; exp_rdchk = !wr;
        exp_rd  = m_read(m_data[idx], off, sz);
        mem_ready_i   = 1'($urandom_range(0, 1));
        mem_rd_data_i = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        rd_obs = bus.rd_data;
        cyc();
        exp_hits++;
        if (wr) begin
            m_data[idx]  = m_write(m_data[idx], off, sz, wd);
            m_dirty[idx] = 1'b1;
        end
        bus.access = 1'b0;
        mem_ready_i = 1'b0;
        exp_hit = 1'b0;
        exp_mv  = 1'b0;
    endtask

    logic [23:0] tags [4] = '{24'h000000, 24'h000001, 24'h000011, 24'hABCDEF};

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          off;
        int          idx;
        cache_access_size_t sz;

        reset_i = 1'b1;
        bus.addr = 32'h100; bus.write = 1'b0; bus.rd_size = WORD; bus.wr_size = WORD;
        bus.wr_data = '0; bus.access = 1'b1;
        mem_ready_i = 1'b0; mem_rd_data_i = '0;
        model_reset();
        main_mem[32'h100] = 128'h44444444_33333333_22222222_DDCCBBAA;
        main_mem[32'h200] = 128'h77777777_66666666_55555555_8899AABB;

        repeat (2) cyc();
        chk("rst_hit", bus.hit, 1'b0);
        chk("rst_mem_valid", mem_valid_o, 1'b0);
        chk("rst_mem_write", mem_write_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_hit_count", hit_count_o, 32'h0);
        chk("rst_miss_count", miss_count_o, 32'h0);
        bus.access = 1'b0;
        reset_i = 1'b0;
        cyc();

        access(32'h100, 1'b0, WORD, 32'h0, 0, 0, rd);
        chk("t1_rd_word", rd, 32'hDDCCBBAA);
        chk("t1_miss_count", miss_count_o, STATS ? 32'd1 : 32'd0);
        chk("t1_hit_count", hit_count_o, STATS ? 32'd1 : 32'd0);

        access(32'h102, 1'b1, BYTE, 32'h0000005A, 0, 0, rd);
        access(32'h100, 1'b0, WORD, 32'h0, 0, 0, rd);
        chk("t2_rd_merged", rd, 32'hDD5ABBAA);

        access(32'h1100, 1'b0, WORD, 32'h0, 1, 5, rd);
        chk("t3_wb_word", wb_obs[31:0], 32'hDD5ABBAA);

        access(32'h202, 1'b0, HALF, 32'h0, 0, 0, rd);
        chk("t4_rd_half", rd, 32'h00008899);

        // Dirty the line, then reset while its writeback is pending.
        access(32'h204, 1'b1, WORD, 32'hCAFEF00D, 0, 0, rd);
        exp_on = 1'b0;
        bus.addr = 32'h2100; bus.write = 1'b0; bus.rd_size = WORD; bus.access = 1'b1;
        mem_ready_i = 1'b0;
        cyc();
        chk("t5_wb_valid", mem_valid_o, 1'b1);
        chk("t5_wb_write", mem_write_o, 1'b1);
        reset_i = 1'b1;
        #1;
        chk("t5_rst_valid", mem_valid_o, 1'b0);
        chk("t5_rst_write", mem_write_o, 1'b0);
        chk("t5_rst_hit", bus.hit, 1'b0);
        cyc();
        reset_i = 1'b0;
        bus.access = 1'b0;
        model_reset();
        cyc();
        access(32'h100, 1'b0, WORD, 32'h0, 0, 0, rd);
        chk("t5_rd_after_rst", rd, 32'hDD5ABBAA);
        chk("t5_miss_count", miss_count_o, STATS ? 32'd1 : 32'd0);

        for (int i = 0; i < 400; i++) begin
            sz  = cache_access_size_t'($urandom_range(0, 2));
            idx = $urandom_range(0, 15);
            off = $urandom_range(0, 15);
            if (sz == HALF) off = off & ~1;
            if (sz == WORD) off = off & ~3;
            a = {tags[$urandom_range(0, 3)], 4'(idx), 4'(off)};
            access(a, 1'($urandom_range(0, 1)), sz, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), rd);
            if ($urandom_range(0, 3) == 0) cyc();
        end

        exp_on = 1'b0;
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
